// File: rtl/trim_dac_sched.sv
// ---------------------------------------------------------------------------
// trim_dac_sched
//
// Sits between uart_decoder and trim_dac_ctrl in the clk40 domain. Keeps the
// trim LUT stable while a 9-channel DAC update is shifting out. Host LUT
// writes that arrive while a load sequence is running, or while older writes
// are still queued, go into a small FIFO. The FIFO drains, one entry per
// cycle, once the scheduler is idle again. Load requests are coalesced into
// a single pending flag.
//
// Optional feature, selected by the macro TRIM_DAC_SCHED_AUTO_REFRESH_EN:
// a free-running refresh timer that raises a load request every
// REFRESH_PERIOD idle cycles while refresh_en is high. Without the macro
// there is no timer and refresh_en is ignored.
//
// Parameters
//   LOAD_CYCLES     cycles busy stays high from the load_dacs strobe on
//   FIFO_DEPTH      write-queue entries (power of 2, >= 2)
//   REFRESH_PERIOD  idle cycles between automatic loads (26-bit counter)
//
// Ports
//   clk40          in   40 MHz system clock
//   rst            in   asynchronous active-high reset
//   host_lut_we    in   host LUT write strobe, one cycle per write
//   host_lut_addr  in   [4:0] host LUT address
//   host_lut_din   in   [6:0] host LUT data
//   host_load_req  in   one-cycle request to load the DACs
//   refresh_en     in   enables the auto-refresh timer (macro builds only)
//   ovf_clr        in   clears the overflow flag
//   lut_we         out  LUT write strobe to trim_dac_ctrl
//   lut_addr       out  [4:0] LUT address to trim_dac_ctrl
//   lut_in         out  [6:0] LUT data to trim_dac_ctrl
//   load_dacs      out  one-cycle load strobe to trim_dac_ctrl
//   busy           out  a DAC load sequence is in progress
//   ovf            out  sticky flag: a queued write was dropped
// ---------------------------------------------------------------------------
module trim_dac_sched #(
    parameter int LOAD_CYCLES    = 640,
    parameter int FIFO_DEPTH     = 4,
    parameter int REFRESH_PERIOD = 40000000
) (
    input  logic       clk40,
    input  logic       rst,
    input  logic       host_lut_we,
    input  logic [4:0] host_lut_addr,
    input  logic [6:0] host_lut_din,
    input  logic       host_load_req,
    input  logic       refresh_en,
    input  logic       ovf_clr,
    output logic       lut_we,
    output logic [4:0] lut_addr,
    output logic [6:0] lut_in,
    output logic       load_dacs,
    output logic       busy,
    output logic       ovf
);

    localparam int CNT_W = $clog2(LOAD_CYCLES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] seq_cnt;
    logic             pending;

    logic [11:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [11:0]      fifo_head;

    logic in_idle;
    logic fifo_empty;
    logic fifo_full;
    logic direct_wr;
    logic push;
    logic pop;
    logic push_ok;
    logic drop;
    logic load_start;
    logic seq_done;
    logic timer_expire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign in_idle    = (state == ST_IDLE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

    // A write bypasses the queue only when nothing older is waiting, so write
    // order is always preserved.
    assign direct_wr = host_lut_we && in_idle && fifo_empty;
    assign push      = host_lut_we && !direct_wr;
    assign pop       = in_idle && !fifo_empty;

    // A pop in the same cycle frees the slot that the push then reuses.
    assign push_ok = push && (!fifo_full || pop);
    assign drop    = push && fifo_full && !pop;

    // The request input counts as pending in its own cycle so that a load can
    // start one cycle after the pulse. Any write in flight or queued goes
    // first.
    assign load_start = in_idle && (pending || host_load_req) &&
                        fifo_empty && !host_lut_we;

    assign seq_done = (seq_cnt == CNT_W'(LOAD_CYCLES - 1));

    // Sequencer: IDLE -> LOAD (strobe cycle) -> BUSY -> IDLE. busy covers
    // LOAD_CYCLES cycles in total, starting with the strobe cycle.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            seq_cnt   <= '0;
            load_dacs <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state     <= ST_LOAD;
                        seq_cnt   <= '0;
                        load_dacs <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD, ST_BUSY: begin
                    load_dacs <= 1'b0;
                    if (seq_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_BUSY;
                        seq_cnt <= seq_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    load_dacs <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Pending load flag. Starting a load consumes it. A request during the
    // strobe cycle or the busy window sets it again, so exactly one
    // follow-up load runs.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (load_start) begin
            pending <= 1'b0;
        end else if (host_load_req || timer_expire) begin
            pending <= 1'b1;
        end
    end

    // Queue storage holds {addr, data}. It has no reset, because the
    // pointers alone decide which entries are valid.
    always_ff @(posedge clk40) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {host_lut_addr, host_lut_din};
        end
    end

    // Queue pointers.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Registered LUT write port. Bypass and pop never coincide, because the
    // bypass needs an empty queue and a pop needs a non-empty one.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            lut_we   <= 1'b0;
            lut_addr <= '0;
            lut_in   <= '0;
        end else begin
            lut_we <= direct_wr || pop;
            if (direct_wr) begin
                lut_addr <= host_lut_addr;
                lut_in   <= host_lut_din;
            end else if (pop) begin
                lut_addr <= fifo_head[11:7];
                lut_in   <= fifo_head[6:0];
            end
        end
    end

    // Sticky overflow. A drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef TRIM_DAC_SCHED_AUTO_REFRESH_EN
    localparam logic [25:0] REFRESH_LAST = 26'(REFRESH_PERIOD - 1);

    logic [25:0] refresh_cnt;

    // The refresh timer counts only while idle. The period is therefore
    // measured from the end of the previous sequence. Expiry sets pending,
    // and the load then starts one cycle later.
    assign timer_expire = refresh_en && in_idle && (refresh_cnt == REFRESH_LAST);

    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (!refresh_en || !in_idle || load_start || timer_expire) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 26'd1;
        end
    end
`else
    logic [26:0] unused_refresh;

    assign timer_expire   = 1'b0;
    assign unused_refresh = {refresh_en, 26'(REFRESH_PERIOD)};
`endif

endmodule

// File: tb/tb_trim_dac_sched.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_trim_dac_sched
//
// Directed bench for trim_dac_sched. A vector table covers the idle
// write-through path and a write that collides with a load request.
// Hand-written sequences cover busy timing, queued writes with a coalesced
// load, FIFO overflow, reset in mid-sequence and the refresh timer.
// ---------------------------------------------------------------------------
module tb_trim_dac_sched;

    localparam int LOAD_CYCLES    = 640;
    localparam int FIFO_DEPTH     = 4;
    localparam int REFRESH_PERIOD = 1000;

    logic       clk40;
    logic       rst;
    logic       host_lut_we;
    logic [4:0] host_lut_addr;
    logic [6:0] host_lut_din;
    logic       host_load_req;
    logic       refresh_en;
    logic       ovf_clr;
    logic       lut_we;
    logic [4:0] lut_addr;
    logic [6:0] lut_in;
    logic       load_dacs;
    logic       busy;
    logic       ovf;

    trim_dac_sched #(
        .LOAD_CYCLES    (LOAD_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) dut (
        .clk40         (clk40),
        .rst           (rst),
        .host_lut_we   (host_lut_we),
        .host_lut_addr (host_lut_addr),
        .host_lut_din  (host_lut_din),
        .host_load_req (host_load_req),
        .refresh_en    (refresh_en),
        .ovf_clr       (ovf_clr),
        .lut_we        (lut_we),
        .lut_addr      (lut_addr),
        .lut_in        (lut_in),
        .load_dacs     (load_dacs),
        .busy          (busy),
        .ovf           (ovf)
    );

    // 10 ns clock.
    initial clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [6:0] din;
        logic       req;
        logic       clr;
        logic       exp_we;
        logic [4:0] exp_addr;
        logic [6:0] exp_din;
        logic       exp_load;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [8];
    int   tests;
    int   fails;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk40);
        #1;
    endtask

    // Drives one cycle of inputs, then returns all strobes to idle.
    task automatic applyStimulus(input logic we, input logic [4:0] addr,
                                 input logic [6:0] din, input logic req,
                                 input logic clr);
        host_lut_we   = we;
        host_lut_addr = addr;
        host_lut_din  = din;
        host_load_req = req;
        ovf_clr       = clr;
        tick();
        host_lut_we   = 1'b0;
        host_load_req = 1'b0;
        ovf_clr       = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("wait_idle_timeout", busy, 0);
    endtask

    // Ticks at least once, then stops on the next load strobe.
    task automatic wait_load(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (load_dacs !== 1'b1 && n < budget);
        checkOutput("wait_load_timeout", load_dacs, 1);
    endtask

    initial begin
        int busy_n;
        int load_n;
        int wr_n;
        int since_load;
        int gap;

        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        host_lut_we   = 1'b0;
        host_lut_addr = '0;
        host_lut_din  = '0;
        host_load_req = 1'b0;
        refresh_en    = 1'b0;
        ovf_clr       = 1'b0;

        vecs[0] = '{1'b1, 5'd5,  7'h2A, 1'b0, 1'b0, 1'b1, 5'd5,  7'h2A, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0,  7'h00, 1'b0, 1'b0, 1'b0, 5'd0,  7'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd0,  7'h00, 1'b0, 1'b0, 1'b1, 5'd0,  7'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd31, 7'h7F, 1'b0, 1'b0, 1'b1, 5'd31, 7'h7F, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 5'd0,  7'h00, 1'b0, 1'b1, 1'b0, 5'd0,  7'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd3,  7'h11, 1'b1, 1'b0, 1'b1, 5'd3,  7'h11, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 5'd0,  7'h00, 1'b0, 1'b0, 1'b0, 5'd0,  7'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 5'd0,  7'h00, 1'b0, 1'b0, 1'b0, 5'd0,  7'h00, 1'b0, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk40);
        #1;
        checkOutput("rst lut_we", lut_we, 0);
        checkOutput("rst lut_addr", lut_addr, 0);
        checkOutput("rst lut_in", lut_in, 0);
        checkOutput("rst load_dacs", load_dacs, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Vector table: idle write-through, then a write that beats a load request.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].req, vecs[i].clr);
            checkOutput($sformatf("vec%0d lut_we", i), lut_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                checkOutput($sformatf("vec%0d lut_addr", i), lut_addr, vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d lut_in", i), lut_in, vecs[i].exp_din);
            end
            checkOutput($sformatf("vec%0d load_dacs", i), load_dacs, vecs[i].exp_load);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
        end
        wait_idle(LOAD_CYCLES + 10);

        // Load timing: strobe on the first cycle, busy for LOAD_CYCLES cycles.
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        checkOutput("t3 load_dacs first", load_dacs, 1);
        checkOutput("t3 busy first", busy, 1);
        busy_n = 0;
        load_n = 0;
        for (int k = 2; k <= LOAD_CYCLES; k++) begin
            tick();
            busy_n += int'(busy);
            load_n += int'(load_dacs);
        end
        checkOutput("t3 busy cycles", busy_n, LOAD_CYCLES - 1);
        checkOutput("t3 extra strobes", load_n, 0);
        tick();
        checkOutput("t3 busy end", busy, 0);
        checkOutput("t3 load_dacs end", load_dacs, 0);

        // Three queued writes plus one load request during busy.
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        checkOutput("t4 load start", load_dacs, 1);
        since_load = 0;
        for (int j = 1; j <= 3; j++) begin
            applyStimulus(1'b1, 5'(j), 7'(j * 16), 1'b0, 1'b0);
            since_load++;
            checkOutput($sformatf("t4 queued%0d lut_we", j), lut_we, 0);
        end
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        since_load++;
        while (busy === 1'b1 && since_load < 2 * LOAD_CYCLES) begin
            tick();
            since_load++;
        end
        checkOutput("t4 busy fall", busy, 0);
        checkOutput("t4 idle lut_we", lut_we, 0);
        for (int j = 1; j <= 3; j++) begin
            tick();
            since_load++;
            checkOutput($sformatf("t4 drain%0d lut_we", j), lut_we, 1);
            checkOutput($sformatf("t4 drain%0d lut_addr", j), lut_addr, j);
            checkOutput($sformatf("t4 drain%0d lut_in", j), lut_in, j * 16);
            checkOutput($sformatf("t4 drain%0d load_dacs", j), load_dacs, 0);
        end
        tick();
        since_load++;
        checkOutput("t4 coalesced load", load_dacs, 1);
        checkOutput("t4 load lut_we", lut_we, 0);
        checkOutput("t4 load spacing", since_load, LOAD_CYCLES + 1 + 3);
        wait_idle(LOAD_CYCLES + 10);
        load_n = 0;
        repeat (5) begin
            tick();
            load_n += int'(load_dacs);
        end
        checkOutput("t4 no third load", load_n, 0);

        // Overflow: six writes into a four-entry queue during busy.
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 5'(8 + j), 7'(8'h40 + j), 1'b0, 1'b0);
        end
        checkOutput("t5 ovf after 4", ovf, 0);
        applyStimulus(1'b1, 5'd20, 7'h55, 1'b0, 1'b0);
        checkOutput("t5 ovf after 5", ovf, 1);
        applyStimulus(1'b1, 5'd21, 7'h56, 1'b0, 1'b1);
        checkOutput("t5 ovf set beats clr", ovf, 1);
        wait_idle(LOAD_CYCLES + 10);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput($sformatf("t5 drain%0d lut_we", j), lut_we, 1);
            checkOutput($sformatf("t5 drain%0d lut_addr", j), lut_addr, 8 + j);
            checkOutput($sformatf("t5 drain%0d lut_in", j), lut_in, 8'h40 + j);
        end
        tick();
        checkOutput("t5 dropped not applied", lut_we, 0);
        checkOutput("t5 no load", load_dacs, 0);
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b0, 1'b1);
        checkOutput("t5 ovf cleared", ovf, 0);

        // Reset mid-busy with a full queue, overflow set and a load pending.
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        repeat (100) tick();
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 5'(j), 7'(j), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 5'd0, 7'd0, 1'b1, 1'b0);
        checkOutput("t1 pre busy", busy, 1);
        checkOutput("t1 pre ovf", ovf, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t1 rst busy", busy, 0);
        checkOutput("t1 rst load_dacs", load_dacs, 0);
        checkOutput("t1 rst lut_we", lut_we, 0);
        checkOutput("t1 rst ovf", ovf, 0);
        tick();
        tick();
        rst    = 1'b0;
        load_n = 0;
        wr_n   = 0;
        busy_n = 0;
        repeat (1500) begin
            tick();
            load_n += int'(load_dacs);
            wr_n   += int'(lut_we);
            busy_n += int'(busy);
        end
        checkOutput("t1 no load after rst", load_n, 0);
        checkOutput("t1 no write after rst", wr_n, 0);
        checkOutput("t1 no busy after rst", busy_n, 0);

        // Refresh timer.
        refresh_en = 1'b1;
`ifdef TRIM_DAC_SCHED_AUTO_REFRESH_EN
        wait_load(3 * REFRESH_PERIOD, gap);
        wait_load(3 * REFRESH_PERIOD, gap);
        checkOutput("t6 refresh period a", gap, REFRESH_PERIOD + LOAD_CYCLES + 1);
        wait_load(3 * REFRESH_PERIOD, gap);
        checkOutput("t6 refresh period b", gap, REFRESH_PERIOD + LOAD_CYCLES + 1);
`else
        load_n = 0;
        repeat (3 * REFRESH_PERIOD) begin
            tick();
            load_n += int'(load_dacs);
        end
        checkOutput("t6 no refresh loads", load_n, 0);
`endif
        refresh_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
